// File: rtl/tick_sequencer.sv
// Tick sequencer: turns decoded pause/run/step/period commands into one-cycle tick pulses,
// with a snapshot handshake that freezes ticking. Define TICK_COUNTER_EN to add o_tick_count.
//
// state | meaning
// IDLE  | no ticking, phase counter held
// RUN   | ticking continuously every eff_period cycles
// STEP  | ticking until steps_left reaches zero, then back to IDLE
// HOLD  | frozen for snapshot; commands refused, previous state kept in saved_q
module tick_sequencer #(
    parameter int          CNT_W      = 24,
    parameter int          STEP_W     = 16,
    parameter int unsigned DEF_PERIOD = 2500000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    input  logic [2:0]        i_cmd_op,
    input  logic [CNT_W-1:0]  i_cmd_arg,
    output logic              o_cmd_ready,
    input  logic              i_snap_req,
    output logic              o_snap_ack,
    output logic              o_tick,
    output logic              o_running,
    output logic              o_step_done,
    output logic [STEP_W-1:0] o_steps_left,
    output logic [31:0]       o_tick_count
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STEP, ST_HOLD} state_t;

    localparam logic [2:0] OP_PAUSE      = 3'd1;
    localparam logic [2:0] OP_RUN        = 3'd2;
    localparam logic [2:0] OP_STEP       = 3'd3;
    localparam logic [2:0] OP_SET_PERIOD = 3'd4;

    state_t              state_q, state_n;
    state_t              saved_q, saved_n;
    logic [CNT_W-1:0]    period_q, period_n;
    logic [CNT_W-1:0]    phase_q, phase_n;
    logic [STEP_W-1:0]   steps_n;
    logic                pend_q, pend_n;
    logic                tick_n, done_n;
    logic                active, tick_gen, cmd_acc, enter_hold;
    logic [CNT_W-1:0]    eff_last;

    assign active   = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign eff_last = (period_q == '0) ? '0 : period_q - CNT_W'(1);
    assign tick_gen = active && (phase_q == eff_last);
    assign cmd_acc  = i_cmd_valid && o_cmd_ready;

    // A snapshot request that collided with a tick or command is remembered in pend_q so that
    // HOLD is still entered on the next cycle even if that cycle would tick again (period 0/1).
    assign enter_hold = (state_q != ST_HOLD) && i_snap_req && !cmd_acc &&
                        (!tick_gen || pend_q);

    always_comb begin
        state_n  = state_q;
        saved_n  = saved_q;
        period_n = period_q;
        phase_n  = phase_q;
        steps_n  = o_steps_left;
        tick_n   = 1'b0;
        done_n   = 1'b0;
        pend_n   = (state_q != ST_HOLD) && i_snap_req && !enter_hold;

        if (active) begin
            if (tick_gen) begin
                if (!enter_hold) begin
                    tick_n  = 1'b1;
                    phase_n = '0;
                    if (state_q == ST_STEP) begin
                        steps_n = o_steps_left - STEP_W'(1);
                        if (o_steps_left == STEP_W'(1)) begin
                            state_n = ST_IDLE;
                            done_n  = 1'b1;
                        end
                    end
                end
            end else begin
                phase_n = phase_q + CNT_W'(1);
            end
        end

        if (enter_hold) begin
            state_n = ST_HOLD;
            saved_n = state_q;
        end

        if ((state_q == ST_HOLD) && !i_snap_req) begin
            state_n = saved_q;
        end

        if (cmd_acc) begin
            case (i_cmd_op)
                OP_PAUSE: begin
                    state_n = ST_IDLE;
                    steps_n = '0;
                end
                OP_RUN: begin
                    state_n = ST_RUN;
                    phase_n = '0;
                    steps_n = '0;
                end
                OP_STEP: begin
                    steps_n = i_cmd_arg[STEP_W-1:0];
                    phase_n = '0;
                    if (i_cmd_arg[STEP_W-1:0] == '0) begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = ST_STEP;
                    end
                end
                OP_SET_PERIOD: begin
                    period_n = i_cmd_arg;
                    phase_n  = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            saved_q      <= ST_IDLE;
            period_q     <= CNT_W'(DEF_PERIOD);
            phase_q      <= '0;
            pend_q       <= 1'b0;
            o_steps_left <= '0;
            o_tick       <= 1'b0;
            o_step_done  <= 1'b0;
            o_snap_ack   <= 1'b0;
            o_cmd_ready  <= 1'b1;
            o_running    <= 1'b0;
        end else begin
            state_q      <= state_n;
            saved_q      <= saved_n;
            period_q     <= period_n;
            phase_q      <= phase_n;
            pend_q       <= pend_n;
            o_steps_left <= steps_n;
            o_tick       <= tick_n;
            o_step_done  <= done_n;
            o_snap_ack   <= (state_n == ST_HOLD);
            o_cmd_ready  <= (state_n != ST_HOLD);
            o_running    <= (state_n == ST_RUN) || (state_n == ST_STEP) ||
                            ((state_n == ST_HOLD) &&
                             ((saved_n == ST_RUN) || (saved_n == ST_STEP)));
        end
    end

`ifdef TICK_COUNTER_EN
    localparam logic [2:0] OP_CLR_COUNT = 3'd5;

    // A clear wins over a tick issued in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_tick_count <= '0;
        end else if (cmd_acc && (i_cmd_op == OP_CLR_COUNT)) begin
            o_tick_count <= '0;
        end else if (tick_n) begin
            o_tick_count <= o_tick_count + 32'd1;
        end
    end
`else
    assign o_tick_count = '0;
`endif

endmodule

// File: tb/tb_tick_sequencer.sv
// Directed bench for tick_sequencer: expected tick/step_done events are queued with their
// cycle numbers when commands are driven, and a negedge monitor pops and compares them.
module tb_tick_sequencer;

    localparam int CNT_W  = 24;
    localparam int STEP_W = 16;
    localparam int DEFP   = 12;

`ifdef TICK_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [2:0] OP_PAUSE = 3'd1;
    localparam logic [2:0] OP_RUN   = 3'd2;
    localparam logic [2:0] OP_STEP  = 3'd3;
    localparam logic [2:0] OP_SET   = 3'd4;
    localparam logic [2:0] OP_CLR   = 3'd5;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_cmd_valid = 1'b0;
    logic [2:0]        i_cmd_op = '0;
    logic [CNT_W-1:0]  i_cmd_arg = '0;
    logic              i_snap_req = 1'b0;
    logic              o_cmd_ready, o_snap_ack, o_tick, o_running, o_step_done;
    logic [STEP_W-1:0] o_steps_left;
    logic [31:0]       o_tick_count;

    tick_sequencer #(.CNT_W(CNT_W), .STEP_W(STEP_W), .DEF_PERIOD(DEFP)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_cmd_valid  (i_cmd_valid),
        .i_cmd_op     (i_cmd_op),
        .i_cmd_arg    (i_cmd_arg),
        .o_cmd_ready  (o_cmd_ready),
        .i_snap_req   (i_snap_req),
        .o_snap_ack   (o_snap_ack),
        .o_tick       (o_tick),
        .o_running    (o_running),
        .o_step_done  (o_step_done),
        .o_steps_left (o_steps_left),
        .o_tick_count (o_tick_count)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        int   cyc;
        logic tick;
        logic done;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_ev;
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_ev(input int c, input logic t, input logic d);
        ev_t e;
        e.cyc  = c;
        e.tick = t;
        e.done = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge i_clk);
    endtask

    task automatic send(input logic [2:0] op, input logic [CNT_W-1:0] arg);
        i_cmd_valid = 1'b1;
        i_cmd_op    = op;
        i_cmd_arg   = arg;
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
        i_cmd_op    = '0;
        i_cmd_arg   = '0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge i_clk);
        end
        #1;
        check(tag, exp_q.size(), 0);
        @(negedge i_clk);
    endtask

    always @(negedge i_clk) begin
        if (o_tick === 1'b1 || o_step_done === 1'b1) begin
            check("event_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                mon_ev = exp_q.pop_front();
                check("event_cycle", cyc, mon_ev.cyc);
                check("event_tick", 32'(o_tick), 32'(mon_ev.tick));
                check("event_done", 32'(o_step_done), 32'(mon_ev.done));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int c;

        repeat (3) @(negedge i_clk);
        check("rst_tick", 32'(o_tick), 0);
        check("rst_done", 32'(o_step_done), 0);
        check("rst_ack", 32'(o_snap_ack), 0);
        check("rst_running", 32'(o_running), 0);
        check("rst_ready", 32'(o_cmd_ready), 1);
        check("rst_steps", 32'(o_steps_left), 0);
        check("rst_count", o_tick_count, 0);
        i_rst = 1'b0;
        @(negedge i_clk);

        // default period after reset
        a = cyc + 1;
        push_ev(a + 12, 1, 0);
        push_ev(a + 24, 1, 0);
        send(OP_RUN, '0);
        check("def_running", 32'(o_running), 1);
        wait_to(a + 25);
        send(OP_PAUSE, '0);
        wait_to(a + 40);
        drain("def_drain");
        check("def_paused", 32'(o_running), 0);

        // period 4 run, then pause
        send(OP_SET, 24'd4);
        a = cyc + 1;
        for (int k = 1; k <= 5; k++) push_ev(a + 4 * k, 1, 0);
        send(OP_RUN, '0);
        wait_to(a + 21);
        send(OP_PAUSE, '0);
        wait_to(a + 34);
        drain("p4_drain");
        check("p4_paused", 32'(o_running), 0);

        // step 5 at period 3
        send(OP_SET, 24'd3);
        a = cyc + 1;
        for (int k = 1; k <= 5; k++) push_ev(a + 3 * k, 1, k == 5);
        send(OP_STEP, 24'd5);
        check("s5_steps_load", 32'(o_steps_left), 5);
        check("s5_running", 32'(o_running), 1);
        wait_to(a + 4);
        check("s5_steps_mid", 32'(o_steps_left), 4);
        wait_to(a + 16);
        check("s5_idle", 32'(o_running), 0);
        check("s5_steps_end", 32'(o_steps_left), 0);
        check("s5_ready", 32'(o_cmd_ready), 1);
        wait_to(a + 24);
        drain("s5_drain");

        // step 0
        a = cyc + 1;
        push_ev(a, 0, 1);
        send(OP_STEP, 24'd0);
        wait_to(a + 6);
        drain("s0_drain");
        check("s0_running", 32'(o_running), 0);

        // snapshot on a tick while running at period 10
        send(OP_SET, 24'd10);
        a = cyc + 1;
        push_ev(a + 10, 1, 0);
        push_ev(a + 40, 1, 0);
        push_ev(a + 50, 1, 0);
        send(OP_RUN, '0);
        wait_to(a + 9);
        i_snap_req = 1'b1;
        @(negedge i_clk);
        check("snap_ack_on_tick", 32'(o_snap_ack), 0);
        @(negedge i_clk);
        check("snap_ack", 32'(o_snap_ack), 1);
        check("snap_ready", 32'(o_cmd_ready), 0);
        check("snap_running", 32'(o_running), 1);
        wait_to(a + 30);
        i_snap_req = 1'b0;
        @(negedge i_clk);
        check("snap_released_ack", 32'(o_snap_ack), 0);
        check("snap_released_ready", 32'(o_cmd_ready), 1);
        wait_to(a + 52);
        send(OP_PAUSE, '0);
        wait_to(a + 62);
        drain("snap_run_drain");

        // step 3 with a snapshot after the first tick; RUN during HOLD is ignored
        send(OP_SET, 24'd3);
        a = cyc + 1;
        push_ev(a + 3, 1, 0);
        push_ev(a + 13, 1, 0);
        push_ev(a + 16, 1, 1);
        send(OP_STEP, 24'd3);
        wait_to(a + 3);
        i_snap_req = 1'b1;
        @(negedge i_clk);
        check("sstep_ack", 32'(o_snap_ack), 1);
        send(OP_RUN, '0);
        wait_to(a + 7);
        check("sstep_steps_held", 32'(o_steps_left), 2);
        check("sstep_running_held", 32'(o_running), 1);
        wait_to(a + 10);
        i_snap_req = 1'b0;
        wait_to(a + 17);
        check("sstep_idle", 32'(o_running), 0);
        check("sstep_steps_end", 32'(o_steps_left), 0);
        wait_to(a + 24);
        drain("sstep_drain");

        // reset in the middle of a step sequence
        a = cyc + 1;
        push_ev(a + 3, 1, 0);
        push_ev(a + 6, 1, 0);
        send(OP_STEP, 24'd9);
        wait_to(a + 7);
        check("mid_steps", 32'(o_steps_left), 7);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("mrst_tick", 32'(o_tick), 0);
        check("mrst_done", 32'(o_step_done), 0);
        check("mrst_running", 32'(o_running), 0);
        check("mrst_ready", 32'(o_cmd_ready), 1);
        check("mrst_steps", 32'(o_steps_left), 0);
        i_rst = 1'b0;
        @(negedge i_clk);
        a = cyc + 1;
        push_ev(a + 12, 1, 0);
        send(OP_RUN, '0);
        wait_to(a + 13);
        send(OP_PAUSE, '0);
        wait_to(a + 26);
        drain("mrst_period_drain");

        // period 0: tick every cycle, tick counter clear and count
        send(OP_SET, 24'd0);
        a = cyc + 1;
        c = a + 5;
        for (int t = a + 1; t <= c + 101; t++) push_ev(t, 1, 0);
        send(OP_RUN, '0);
        wait_to(a + 4);
        send(OP_CLR, '0);
        check("cnt_clr_with_tick", o_tick_count, 0);
        wait_to(c + 100);
        check("cnt_100", o_tick_count, CNT_EN ? 32'd100 : 32'd0);
        i_snap_req = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        check("p0_hold_ack", 32'(o_snap_ack), 1);
        check("p0_hold_running", 32'(o_running), 1);
        check("cnt_101", o_tick_count, CNT_EN ? 32'd101 : 32'd0);
        wait_to(c + 108);
        drain("p0_drain");

        // reset while held
        i_rst = 1'b1;
        @(negedge i_clk);
        check("hrst_ack", 32'(o_snap_ack), 0);
        check("hrst_running", 32'(o_running), 0);
        check("hrst_ready", 32'(o_cmd_ready), 1);
        check("hrst_count", o_tick_count, 0);
        i_rst = 1'b0;
        i_snap_req = 1'b0;
        repeat (3) @(negedge i_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
